// File: rtl/period_meter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// period_meter
//
// Measures the number of clk_in cycles between consecutive rising edges of an
// asynchronous strobe and presents each result on a valid/ready port.
//
// State table
//   state      | meaning
//   -----------+---------------------------------------------------------------
//   ST_IDLE    | measurement disabled, counter cleared
//   ST_ARMED   | enabled, waiting for the first edge (which gives no result)
//   ST_MEASURE | counting cycles since the last edge; each edge captures a period
//
// Parameters
//   COUNT_WIDTH  width of the period counter and of period_out
//   SYNC_STAGES  number of synchronizer flops on event_in (must be >= 2)
//
// Ports
//   clk_in        system clock
//   reset_in      asynchronous active-low reset
//   enable_in     measurement enable
//   event_in      asynchronous strobe being measured
//   period_out    measured period in cycles (all-ones when saturated)
//   overflow_out  period_out is saturated
//   valid_out     result available
//   ready_in      consumer accepts the result
//   missed_out    sticky: a completed measurement was discarded
// -----------------------------------------------------------------------------
module period_meter #(
    parameter int COUNT_WIDTH = 26,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk_in,
    input  logic                   reset_in,
    input  logic                   enable_in,
    input  logic                   event_in,
    output logic [COUNT_WIDTH-1:0] period_out,
    output logic                   overflow_out,
    output logic                   valid_out,
    input  logic                   ready_in,
    output logic                   missed_out
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

    state_t                   state_q;
    state_t                   state_d;
    logic [COUNT_WIDTH-1:0]   cnt_q;
    logic [COUNT_WIDTH-1:0]   cnt_d;
    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     prev_q;
    logic                     event_edge;
    logic                     capture;
    logic                     transfer;

    // Synchronizer chain; the last stage is the clean strobe, prev_q lags it
    // by one cycle for rising-edge detection.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], event_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Edges are ignored whenever enable_in is low, including the cycle it falls.
    assign event_edge = sync_q[SYNC_STAGES-1] & ~prev_q & enable_in;
    assign transfer   = valid_out & ready_in;

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        if (!enable_in) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ARMED;
                    cnt_d   = '0;
                end
                ST_ARMED: begin
                    if (event_edge) begin
                        state_d = ST_MEASURE;
                        cnt_d   = CNT_ONE;
                    end
                end
                ST_MEASURE: begin
                    if (event_edge) begin
                        capture = 1'b1;
                        cnt_d   = CNT_ONE;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output register. A capture is loaded when the slot is empty or is being
    // emptied this same cycle; otherwise the new result is dropped and flagged.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            period_out   <= '0;
            overflow_out <= 1'b0;
            valid_out    <= 1'b0;
        end else if (capture && (!valid_out || ready_in)) begin
            period_out   <= cnt_q;
            overflow_out <= (cnt_q == CNT_MAX);
            valid_out    <= 1'b1;
        end else if (transfer) begin
            valid_out    <= 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            missed_out <= 1'b0;
        end else if (!enable_in) begin
            missed_out <= 1'b0;
        end else if (capture && valid_out && !ready_in) begin
            missed_out <= 1'b1;
        end
    end

endmodule
